// File: rtl/fetch_stage_pkg.sv
// Shared constants and FSM encoding for the single-cycle instruction fetch stage.
// Fetch addresses are 8 bits wide and wrap modulo 256.
package fetch_stage_pkg;

    localparam logic [7:0]  PC_RESET  = 8'h00;
    localparam logic [7:0]  PC_STEP   = 8'd1;
    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_pc_incr.sv
// Purpose: 8-bit fetch address incrementer, wraps modulo 256.
// Latency: combinational.
// Backpressure: none.
module pc_incr
    import fetch_stage_pkg::*;
(
    input  logic [7:0] pc_in,
    output logic [7:0] pc_out
);

    assign pc_out = pc_in + PC_STEP;

endmodule

// File: rtl/fetch_stage.sv
// Purpose: drives an external sync-read instruction memory and presents fetched instr/pc.
// Latency: address in cycle N -> instr valid in cycle N+1; redirect costs no bubble.
// Backpressure: stall holds pc state and re-reads the current address so q_pc stays stable.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [7:0]  redirect_pc,
    input  logic [7:0]  q_pc,
    output logic [7:0]  address_pc,
    output logic [7:0]  instr,
    output logic [7:0]  instr_pc,
    output logic        instr_valid,
    output logic [15:0] fetch_count
);

    fetch_state_t state, state_nxt;
    logic [7:0]   pc_r, pc_nxt;
    logic [7:0]   f2_pc, f2_nxt;
    logic [7:0]   incr_in, incr_out;
    logic         accept;

    // One incrementer serves both the sequential and the redirect path.
    assign incr_in = redirect ? redirect_pc : pc_r;

    pc_incr u_pc_incr (
        .pc_in  (incr_in),
        .pc_out (incr_out)
    );

    assign address_pc  = redirect ? redirect_pc : (stall ? f2_pc : pc_r);
    assign instr       = q_pc;
    assign instr_pc    = f2_pc;
    assign instr_valid = (state == RUN) && !redirect;
    assign accept      = instr_valid && !stall;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_r;
        f2_nxt    = f2_pc;
        if (redirect) begin
            f2_nxt    = redirect_pc;
            pc_nxt    = incr_out;
            state_nxt = RUN;
        end else if (!stall) begin
            f2_nxt    = pc_r;
            pc_nxt    = incr_out;
            state_nxt = RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= BOOT;
            pc_r        <= PC_RESET;
            f2_pc       <= PC_RESET;
            fetch_count <= '0;
        end else begin
            state <= state_nxt;
            pc_r  <= pc_nxt;
            f2_pc <= f2_nxt;
            if (accept && (fetch_count != COUNT_MAX)) begin
                fetch_count <= fetch_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a sync-read instruction memory model (mem[i] = i ^ 8'hA5).
module tb_fetch_stage;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic [7:0]  q_pc;
    logic [7:0]  address_pc;
    logic [7:0]  instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic [15:0] fetch_count;

    logic [7:0]  mem [0:255];
    int          errors;
    int          checks;

    localparam logic [7:0] RUN_INSTR [5] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6, 8'hA1};

    fetch_stage dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .q_pc        (q_pc),
        .address_pc  (address_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .fetch_count (fetch_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) q_pc <= mem[address_pc];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic r, input logic s, input logic rd, input logic [7:0] rpc);
        reset       = r;
        stall       = s;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 256; i++) mem[i] = i[7:0] ^ 8'hA5;
        q_pc = 8'h00;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;

        // Reset and free run
        cyc();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_addr",  32'(address_pc),  32'h00);
        chk("rst_ipc",   32'(instr_pc),    32'h00);
        chk("rst_cnt",   32'(fetch_count), 32'd0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("run_valid", 32'(instr_valid), 32'd1);
            chk("run_ipc",   32'(instr_pc),    32'(k));
            chk("run_instr", 32'(instr),       32'(RUN_INSTR[k]));
        end
        chk("run_cnt", 32'(fetch_count), 32'd4);

        // Stall for three cycles on instr_pc 03
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 4; k++) cyc();
        for (int j = 0; j < 3; j++) begin
            if (j > 0) cyc();
            drive(1'b0, 1'b1, 1'b0, 8'h00);
            chk("stall_ipc",   32'(instr_pc),    32'h03);
            chk("stall_instr", 32'(instr),       32'hA6);
            chk("stall_addr",  32'(address_pc),  32'h03);
            chk("stall_cnt",   32'(fetch_count), 32'd3);
        end
        cyc();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("unstall_ipc", 32'(instr_pc),    32'h03);
        chk("unstall_cnt", 32'(fetch_count), 32'd3);
        cyc();
        chk("post_stall_ipc",   32'(instr_pc),    32'h04);
        chk("post_stall_instr", 32'(instr),       32'hA1);
        chk("post_stall_cnt",   32'(fetch_count), 32'd4);

        // Redirect to 10, then to 40 while instr_pc=10
        drive(1'b0, 1'b0, 1'b1, 8'h10);
        chk("redir1_valid", 32'(instr_valid), 32'd0);
        chk("redir1_addr",  32'(address_pc),  32'h10);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("redir1_ipc",   32'(instr_pc), 32'h10);
        chk("redir1_instr", 32'(instr),    32'hB5);
        drive(1'b0, 1'b0, 1'b1, 8'h40);
        chk("redir2_valid", 32'(instr_valid), 32'd0);
        chk("redir2_addr",  32'(address_pc),  32'h40);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("redir2_ipc",   32'(instr_pc),    32'h40);
        chk("redir2_instr", 32'(instr),       32'hE5);
        chk("redir2_cnt",   32'(fetch_count), 32'd4);
        cyc();
        chk("redir2_ipc_n", 32'(instr_pc),    32'h41);
        chk("redir2_ins_n", 32'(instr),       32'hE4);
        chk("redir2_cnt_n", 32'(fetch_count), 32'd5);

        // Redirect and stall together
        drive(1'b0, 1'b1, 1'b1, 8'h20);
        chk("rs_valid", 32'(instr_valid), 32'd0);
        chk("rs_addr",  32'(address_pc),  32'h20);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("rs_ipc",   32'(instr_pc),    32'h20);
        chk("rs_instr", 32'(instr),       32'h85);
        chk("rs_cnt",   32'(fetch_count), 32'd5);
        cyc();
        chk("rs_ipc_n", 32'(instr_pc),    32'h21);
        chk("rs_cnt_n", 32'(fetch_count), 32'd6);

        // PC wrap FE -> FF -> 00, and redirect to FF
        drive(1'b0, 1'b0, 1'b1, 8'hFE);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("wrap_ipc_fe",   32'(instr_pc), 32'hFE);
        chk("wrap_instr_fe", 32'(instr),    32'h5B);
        cyc();
        chk("wrap_ipc_ff",   32'(instr_pc), 32'hFF);
        cyc();
        chk("wrap_ipc_00",   32'(instr_pc), 32'h00);
        chk("wrap_instr_00", 32'(instr),    32'hA5);
        drive(1'b0, 1'b0, 1'b1, 8'hFF);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("rff_ipc",  32'(instr_pc),    32'hFF);
        chk("rff_addr", 32'(address_pc),  32'h00);
        chk("rff_cnt",  32'(fetch_count), 32'd8);

        // Long free run into counter saturation
        for (int n = 0; n < 65526; n++) cyc();
        chk("sat_fffe", 32'(fetch_count), 32'hFFFE);
        cyc();
        chk("sat_ffff", 32'(fetch_count), 32'hFFFF);
        cyc();
        chk("sat_hold_valid", 32'(instr_valid), 32'd1);
        chk("sat_hold",       32'(fetch_count), 32'hFFFF);
        cyc();
        chk("sat_hold2",      32'(fetch_count), 32'hFFFF);

        // Reset during a stall at instr_pc 33
        drive(1'b0, 1'b0, 1'b1, 8'h30);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 3; k++) cyc();
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        chk("rstall_ipc",   32'(instr_pc), 32'h33);
        chk("rstall_instr", 32'(instr),    32'h96);
        cyc();
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        chk("rstall_hold", 32'(instr_pc), 32'h33);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("rstall_valid", 32'(instr_valid), 32'd0);
        chk("rstall_addr",  32'(address_pc),  32'h00);
        chk("rstall_ipc0",  32'(instr_pc),    32'h00);
        chk("rstall_cnt",   32'(fetch_count), 32'd0);
        cyc();
        chk("resume_valid", 32'(instr_valid), 32'd1);
        chk("resume_ipc",   32'(instr_pc),    32'h00);
        chk("resume_instr", 32'(instr),       32'hA5);
        chk("resume_cnt",   32'(fetch_count), 32'd0);
        cyc();
        chk("resume_ipc_n", 32'(instr_pc),    32'h01);
        chk("resume_cnt_n", 32'(fetch_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 clock  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high; sampled on rising edge of clock.
REQ-003 stall  in  1  downstream not accepting instr this cycle.
REQ-004 redirect  in  1  taken branch; fetch restarts at redirect_pc.
REQ-005 redirect_pc  in  8  branch target address.
REQ-006 q_pc  in  8  instruction memory read data; synchronous read, word at address_pc sampled on edge N appears during cycle N+1.
REQ-007 address_pc  out  8  instruction memory read address (combinational).
REQ-008 instr  out  8  fetched instruction; equals q_pc.
REQ-009 instr_pc  out  8  address of instr.
REQ-010 instr_valid  out  1  instr/instr_pc hold a live instruction.
REQ-011 fetch_count  out  16  count of instructions accepted downstream.

Function
REQ-012 State: pc_r (next fetch address, 8b), f2_pc (8b), FSM state {BOOT, RUN}, fetch_count (16b).
REQ-013 address_pc = redirect ? redirect_pc : (stall ? f2_pc : pc_r); redirect has priority over stall.
REQ-014 instr_valid = (state==RUN) & ~redirect; instr_pc = f2_pc.
REQ-015 Advance edge (~redirect, ~stall): f2_pc<=pc_r; pc_r<=pc_r+1; state<=RUN.
REQ-016 Stall edge (~redirect, stall): pc_r, f2_pc, state unchanged; re-read of f2_pc keeps q_pc stable on the following cycle.
REQ-017 Redirect edge: f2_pc<=redirect_pc; pc_r<=redirect_pc+1; state<=RUN; instruction shown in the redirect cycle is discarded.
REQ-018 FSM: BOOT->RUN on first advance or redirect edge; BOOT->BOOT on stall; RUN never returns to BOOT except by reset.
REQ-019 Accept = instr_valid & ~stall; fetch_count increments on each accept edge and saturates at 16'hFFFF.
REQ-020 PC arithmetic modulo 256: pc_r 8'hFF advances to 8'h00; redirect_pc 8'hFF gives pc_r 8'h00.
REQ-021 Latency: address presented in cycle N -> instr valid in cycle N+1 (single-cycle fetch, zero-bubble redirect).
REQ-022 Redirect and stall together: redirect rules apply; stall ignored for that edge.

Reset
REQ-023 On reset edge: pc_r=8'h00, f2_pc=8'h00, state=BOOT, fetch_count=0.
REQ-024 Outputs in the cycle after a reset edge: address_pc=8'h00 (absent redirect), instr_valid=0, instr_pc=8'h00, fetch_count=0.
REQ-025 Reset overrides stall and redirect on the same edge; reset mid-stall or mid-redirect discards all in-flight fetch state.

Structure
REQ-026 Shared package holds PC_RESET (8'h00), PC_STEP (8'd1), COUNT_MAX (16'hFFFF) and the BOOT/RUN state encoding.
REQ-027 The 8-bit incrementer is a separate sub-module pc_incr (out = in + PC_STEP, carry dropped), instantiated once for both pc_r+1 and redirect_pc+1 via an input mux.
REQ-028 No memory inside the block; the instruction memory is external.

Verification
REQ-029 Reset then free-run with mem[i]=i^8'hA5, no stall -> cycle 1 after reset: instr_valid=0; cycles 2..6: instr_pc=0..4, instr=A5,A4,A7,A6,A1; fetch_count=4 after 5 accepts minus the last in flight.
REQ-030 Stall asserted 3 cycles while instr_pc=8'h03 -> instr_pc=03 and instr=mem[3] held for all 3 cycles, address_pc=03; fetch_count unchanged; next cycle instr_pc=04.
REQ-031 redirect=1, redirect_pc=8'h40 while instr_pc=8'h10 -> that cycle instr_valid=0, address_pc=40; next cycle instr_pc=40, instr=mem[40], then 41.
REQ-032 redirect and stall asserted together, redirect_pc=8'h20 -> behaves as REQ-031 (instr_pc=20 next cycle).
REQ-033 Run to pc 8'hFE then 8'hFF -> next instr_pc=8'h00 (wrap); preload fetch_count near max by a long run or forced start -> holds at 16'hFFFF.
REQ-034 Assert reset during a stall at instr_pc=8'h33 -> next cycle instr_valid=0, address_pc=00, fetch_count=0, then fetch resumes at 00.
